// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding data-bus access, lane steering, load extension.
// Ports: cpu_clk/cpu_rst_n, pipeline request (mem_req..rd_in, stall, err), data bus, write-back.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst_n,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [4:0]  rd_in,
  output logic        stall,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [4:0]  rd_q;

  logic        f3_ok;
  logic        aligned;
  logic        legal;
  logic        is_b;
  logic        is_h;
  logic [3:0]  be_n;
  logic [31:0] wd_n;
  logic [31:0] sh;
  logic [15:0] half;
  logic [31:0] ld_data;

  assign is_b = (funct3[1:0] == 2'd0);
  assign is_h = (funct3[1:0] == 2'd1);

  always_comb begin
    f3_ok   = 1'b0;
    aligned = 1'b1;
    case (funct3)
      3'd0, 3'd1, 3'd2: f3_ok = 1'b1;
      3'd4, 3'd5:       f3_ok = ~mem_we;
      default:          f3_ok = 1'b0;
    endcase
    if (funct3[1:0] == 2'd1)
      aligned = ~addr[0];
    else if (funct3[1:0] == 2'd2)
      aligned = (addr[1:0] == 2'b00);
    legal = f3_ok & aligned;
  end

  always_comb begin
    be_n = 4'b1111;
    wd_n = '0;
    if (mem_we) begin
      unique case (1'b1)
        is_b: begin
          be_n = 4'b0001 << addr[1:0];
          wd_n = {4{wdata[7:0]}};
        end
        is_h: begin
          be_n = addr[1] ? 4'b1100 : 4'b0011;
          wd_n = {2{wdata[15:0]}};
        end
        default: wd_n = wdata;
      endcase
    end
  end

  always_comb begin
    sh   = bus_rdata >> {lane_q, 3'b000};
    half = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (f3_q)
      3'd0:    ld_data = {{24{sh[7]}}, sh[7:0]};
      3'd1:    ld_data = {{16{half[15]}}, half};
      3'd4:    ld_data = {24'b0, sh[7:0]};
      3'd5:    ld_data = {16'b0, half};
      default: ld_data = bus_rdata;
    endcase
  end

  assign stall = ((state == IDLE) & mem_req & legal) | (state == BUS);

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      f3_q      <= '0;
      lane_q    <= '0;
      rd_q      <= '0;
      err       <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_be    <= '0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
    end else begin
      err      <= 1'b0;
      wb_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (mem_req) begin
            if (legal) begin
              state     <= BUS;
              wait_cnt  <= '0;
              bus_req   <= 1'b1;
              bus_we    <= mem_we;
              bus_addr  <= {addr[31:2], 2'b00};
              bus_wdata <= wd_n;
              bus_be    <= be_n;
              f3_q      <= funct3;
              lane_q    <= addr[1:0];
              rd_q      <= rd_in;
            end else begin
              err <= 1'b1;
            end
          end
        end
        BUS: begin
          if (bus_ack) begin
            state   <= DONE;
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            if (!bus_we) begin
              wb_valid <= 1'b1;
              wb_rd    <= rd_q;
              wb_data  <= ld_data;
            end
          end else if (wait_cnt == LAST) begin
            state   <= DONE;
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            err     <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed vector table, hand sequences,
// and random accesses checked against a behavioural model.
module tb_load_store_unit;

  localparam int TO = 16;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst_n = 1'b0;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [4:0]  rd_in = '0;
  logic        stall;
  logic        err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int total = 0;
  int bad = 0;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .cpu_clk   (cpu_clk),
    .cpu_rst_n (cpu_rst_n),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .rd_in     (rd_in),
    .stall     (stall),
    .err       (err),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_be    (bus_be),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data)
  );

  always #5 cpu_clk = ~cpu_clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [4:0]  rd;
    int          delay;
    logic [31:0] rdt;
    logic        lg;
    logic [3:0]  be;
    logic [31:0] bwd;
    logic [31:0] wbd;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] outs_all();
    return 128'({stall, err, bus_req, bus_we, bus_addr, bus_wdata,
                 bus_be, wb_valid, wb_rd, wb_data});
  endfunction

  // Expected behaviour from the access rules, using plain arithmetic.
  task automatic model(input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rdt, output logic lg,
                       output logic [3:0] be, output logic [31:0] bwd,
                       output logic [31:0] wbd);
    int sz;
    int off;
    int bits;
    longint v;
    sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off = int'(a[1:0]);
    lg  = (we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7))
          && (f3[1:0] != 2'd3) && (off % sz == 0);
    wbd = '0;
    if (we) begin
      be  = 4'(((1 << sz) - 1) << off);
      bwd = (sz == 1) ? 32'(wd[7:0]) * 32'h0101_0101 :
            (sz == 2) ? 32'(wd[15:0]) * 32'h0001_0001 : wd;
    end else begin
      be   = 4'hF;
      bwd  = '0;
      bits = 8 * sz;
      v    = longint'({32'b0, rdt}) >> (8 * off);
      v    = v & ((64'sd1 << bits) - 1);
      if (!f3[2] && sz < 4 && v >= (64'sd1 << (bits - 1)))
        v = v - (64'sd1 << bits);
      wbd = v[31:0];
    end
  endtask

  task automatic txn(input logic we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [4:0] rd, input int delay,
                     input logic [31:0] rdt, input logic lg,
                     input logic [3:0] be, input logic [31:0] bwd,
                     input logic [31:0] wbd);
    logic tmo;
    logic expwb;
    logic [70:0] busv;
    tmo   = lg && (delay >= TO);
    expwb = lg && !we && !tmo;
    busv  = {1'b1, we, be, a & 32'hFFFF_FFFC, bwd, 1'b1};
    @(negedge cpu_clk);
    mem_req = 1'b1;
    mem_we  = we;
    funct3  = f3;
    addr    = a;
    wdata   = wd;
    rd_in   = rd;
    #1;
    chk("accept_stall", 128'(stall), 128'(lg));
    chk("accept_bus_req", 128'(bus_req), 128'(1'b0));
    @(negedge cpu_clk);
    mem_req = 1'b0;
    wdata   = $urandom;
    addr    = $urandom;
    #1;
    if (!lg) begin
      chk("illegal_err", 128'(err), 128'(1'b1));
      chk("illegal_bus_req", 128'(bus_req), 128'(1'b0));
      @(negedge cpu_clk);
      #1;
      chk("illegal_err_end", 128'(err), 128'(1'b0));
      chk("illegal_bus_req2", 128'(bus_req), 128'(1'b0));
      return;
    end
    for (int i = 0; i < TO; i++) begin
      chk("bus_fields", 128'({bus_req, bus_we, bus_be, bus_addr,
                              bus_wdata, stall}), 128'(busv));
      chk("bus_err", 128'(err), 128'(1'b0));
      bus_rdata = $urandom;
      if (i == delay) begin
        bus_ack   = 1'b1;
        bus_rdata = rdt;
      end
      @(negedge cpu_clk);
      bus_ack   = 1'b0;
      bus_rdata = $urandom;
      #1;
      if (i == delay) break;
    end
    chk("done_stall", 128'(stall), 128'(1'b0));
    chk("done_bus_req", 128'(bus_req), 128'(1'b0));
    chk("done_err", 128'(err), 128'(tmo));
    chk("done_wb_valid", 128'(wb_valid), 128'(expwb));
    if (expwb) begin
      chk("wb_data", 128'(wb_data), 128'(wbd));
      chk("wb_rd", 128'(wb_rd), 128'(rd));
    end
    @(negedge cpu_clk);
    #1;
    chk("post_wb_valid", 128'(wb_valid), 128'(1'b0));
    chk("post_err", 128'(err), 128'(1'b0));
    chk("post_bus_req", 128'(bus_req), 128'(1'b0));
    if (expwb) chk("wb_hold", 128'(wb_data), 128'(wbd));
  endtask

  initial begin
    logic lg;
    logic [3:0] be;
    logic [31:0] bwd;
    logic [31:0] wbd;
    logic we;
    logic [2:0] f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rdt;
    int r;
    int dl;

    //          we    f3    addr          wdata         rd     dly rdata         legal be     bus_wdata     wb_data
    tbl[0]  = '{1'b0, 3'd0, 32'h0000_1003, 32'h0,        5'd7,  0,  32'h80FF_1234, 1'b1, 4'hF, 32'h0,        32'hFFFF_FF80};
    tbl[1]  = '{1'b1, 3'd1, 32'h0000_2002, 32'h0000_ABCD, 5'd1,  0,  32'h0,        1'b1, 4'hC, 32'hABCD_ABCD, 32'h0};
    tbl[2]  = '{1'b0, 3'd2, 32'h0000_3001, 32'h0,        5'd2,  0,  32'h0,        1'b0, 4'h0, 32'h0,        32'h0};
    tbl[3]  = '{1'b0, 3'd5, 32'h0000_4002, 32'h0,        5'd9,  5,  32'hF00D_0000, 1'b1, 4'hF, 32'h0,        32'h0000_F00D};
    tbl[4]  = '{1'b0, 3'd2, 32'h0000_5000, 32'h0,        5'd3,  99, 32'h0,        1'b1, 4'hF, 32'h0,        32'h0};
    tbl[5]  = '{1'b1, 3'd0, 32'h0000_0011, 32'h0000_005A, 5'd4,  1,  32'h0,        1'b1, 4'h2, 32'h5A5A_5A5A, 32'h0};
    tbl[6]  = '{1'b1, 3'd2, 32'h0000_0020, 32'hDEAD_BEEF, 5'd5,  0,  32'h0,        1'b1, 4'hF, 32'hDEAD_BEEF, 32'h0};
    tbl[7]  = '{1'b0, 3'd4, 32'h0000_0022, 32'h0,        5'd6,  0,  32'h1122_3344, 1'b1, 4'hF, 32'h0,        32'h0000_0022};
    tbl[8]  = '{1'b0, 3'd1, 32'h0000_0030, 32'h0,        5'd8,  3,  32'h1234_8001, 1'b1, 4'hF, 32'h0,        32'hFFFF_8001};
    tbl[9]  = '{1'b0, 3'd2, 32'h0000_0040, 32'h0,        5'd31, 2,  32'hCAFE_F00D, 1'b1, 4'hF, 32'h0,        32'hCAFE_F00D};
    tbl[10] = '{1'b1, 3'd1, 32'h0000_0001, 32'h1234,     5'd1,  0,  32'h0,        1'b0, 4'h0, 32'h0,        32'h0};
    tbl[11] = '{1'b0, 3'd3, 32'h0000_0000, 32'h0,        5'd1,  0,  32'h0,        1'b0, 4'h0, 32'h0,        32'h0};
    tbl[12] = '{1'b1, 3'd4, 32'h0000_0000, 32'h0,        5'd1,  0,  32'h0,        1'b0, 4'h0, 32'h0,        32'h0};
    tbl[13] = '{1'b0, 3'd0, 32'h0000_0000, 32'h0,        5'd0,  0,  32'h0000_00FE, 1'b1, 4'hF, 32'h0,        32'hFFFF_FFFE};
    tbl[14] = '{1'b0, 3'd2, 32'h0000_0050, 32'h0,        5'd12, 15, 32'h1357_9BDF, 1'b1, 4'hF, 32'h0,        32'h1357_9BDF};
    tbl[15] = '{1'b1, 3'd0, 32'h0000_0003, 32'h1234_56C3, 5'd2,  0,  32'h0,        1'b1, 4'h8, 32'hC3C3_C3C3, 32'h0};

    repeat (3) @(negedge cpu_clk);
    #1;
    chk("reset_outputs", outs_all(), 128'(0));
    cpu_rst_n = 1'b1;

    for (int i = 0; i < 16; i++)
      txn(tbl[i].we, tbl[i].f3, tbl[i].a, tbl[i].wd, tbl[i].rd,
          tbl[i].delay, tbl[i].rdt, tbl[i].lg, tbl[i].be, tbl[i].bwd,
          tbl[i].wbd);

    // bus_ack while idle must not produce anything
    @(negedge cpu_clk);
    bus_ack   = 1'b1;
    bus_rdata = 32'h5555_AAAA;
    @(negedge cpu_clk);
    bus_ack = 1'b0;
    #1;
    chk("stray_ack_wb", 128'(wb_valid), 128'(1'b0));
    chk("stray_ack_bus", 128'(bus_req), 128'(1'b0));

    // mem_req held high through BUS and DONE must not start a new access
    @(negedge cpu_clk);
    mem_req = 1'b1;
    mem_we  = 1'b0;
    funct3  = 3'd2;
    addr    = 32'h0000_0070;
    rd_in   = 5'd10;
    @(negedge cpu_clk);
    bus_ack   = 1'b1;
    bus_rdata = 32'h0BAD_F00D;
    @(negedge cpu_clk);
    bus_ack = 1'b0;
    #1;
    chk("held_done_stall", 128'(stall), 128'(1'b0));
    chk("held_done_wb", 128'({wb_valid, wb_data}), 128'({1'b1, 32'h0BAD_F00D}));
    @(negedge cpu_clk);
    mem_req = 1'b0;
    #1;
    chk("held_no_restart", 128'(bus_req), 128'(1'b0));

    // reset in the second BUS cycle of a load
    @(negedge cpu_clk);
    mem_req = 1'b1;
    mem_we  = 1'b0;
    funct3  = 3'd2;
    addr    = 32'h0000_0060;
    rd_in   = 5'd11;
    @(negedge cpu_clk);
    mem_req = 1'b0;
    @(negedge cpu_clk);
    #1;
    chk("pre_reset_bus_req", 128'(bus_req), 128'(1'b1));
    cpu_rst_n = 1'b0;
    #1;
    chk("midbus_reset", outs_all(), 128'(0));
    @(negedge cpu_clk);
    cpu_rst_n = 1'b1;
    @(negedge cpu_clk);
    #1;
    chk("after_reset", outs_all(), 128'(0));
    txn(1'b1, 3'd2, 32'h0000_0010, 32'h0102_0304, 5'd0, 0, 32'h0,
        1'b1, 4'hF, 32'h0102_0304, 32'h0);

    for (int n = 0; n < 40; n++) begin
      we  = 1'($urandom_range(0, 1));
      f3  = 3'($urandom_range(0, 7));
      a   = $urandom;
      wd  = $urandom;
      rdt = $urandom;
      r   = $urandom_range(0, 9);
      dl  = (r == 9) ? 20 : r % 4;
      model(we, f3, a, wd, rdt, lg, be, bwd, wbd);
      txn(we, f3, a, wd, 5'($urandom_range(0, 31)), dl, rdt, lg, be, bwd, wbd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
